// File: rtl/puf_resp_pkg.sv
// rtl/puf_resp_pkg.sv - shared state encoding and width helpers for the PUF response collector
package puf_resp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      FIRE   = 3'd2,
      SAMPLE = 3'd3,
      VOTE   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int DEF_RESP_BITS     = 32;
   localparam int DEF_NUM_EVAL      = 5;
   localparam int DEF_SETTLE_CYCLES = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   // Bits needed to hold the values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int SETTLE_W = cnt_width(DEF_SETTLE_CYCLES - 1);
   localparam int EVAL_W   = cnt_width(DEF_NUM_EVAL - 1);
   localparam int BIT_W    = cnt_width(DEF_RESP_BITS - 1);

endpackage

// File: rtl/puf_bit_sync.sv
// rtl/puf_bit_sync.sv - two-flop synchronizer for the asynchronous XOR network output
module puf_bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - fires the PDL PUF, majority-votes repeated samples per challenge
// and assembles RESP_BITS voted bits into one word with an unstable-bit count.
module puf_response_collector
   import puf_resp_pkg::*;
#(
   parameter int RESP_BITS     = DEF_RESP_BITS,
   parameter int NUM_EVAL      = DEF_NUM_EVAL,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   localparam int UW           = clog2(RESP_BITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 puf_trigger,
   output logic                 chal_next,
   input  logic                 xor_response,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [UW-1:0]        unstable_cnt
);

   localparam int SW = cnt_width(SETTLE_CYCLES - 1);
   localparam int EW = cnt_width(NUM_EVAL - 1);
   localparam int OW = cnt_width(NUM_EVAL);
   localparam int BW = cnt_width(RESP_BITS - 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [EW-1:0] EVAL_LAST   = EW'(NUM_EVAL - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
   localparam logic [OW-1:0] ONES_HALF   = OW'(NUM_EVAL / 2);
   localparam logic [OW-1:0] ONES_ALL    = OW'(NUM_EVAL);

   state_t        state, state_nxt;
   logic [SW-1:0] settle_cnt;
   logic [EW-1:0] eval_cnt;
   logic [OW-1:0] ones_cnt;
   logic [BW-1:0] bit_cnt;
   logic          sampled;
   logic          settle_done;
   logic          vote_bit;

   puf_bit_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (xor_response),
      .q     (sampled)
   );

   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign vote_bit    = (ones_cnt > ONES_HALF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      puf_trigger = 1'b0;
      chal_next   = 1'b0;
      resp_valid  = 1'b0;
      unique case (state)
         IDLE:   if (start) state_nxt = ARM;
         ARM:    if (settle_done) state_nxt = FIRE;
         FIRE: begin
            puf_trigger = 1'b1;
            if (settle_done) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            puf_trigger = 1'b1;
            state_nxt   = (eval_cnt == EVAL_LAST) ? VOTE : ARM;
         end
         VOTE: begin
            chal_next = 1'b1;
            state_nxt = (bit_cnt == BIT_LAST) ? DONE : ARM;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Settle timer runs only while the lines are discharging or racing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if ((state == ARM) || (state == FIRE)) begin
         settle_cnt <= settle_done ? '0 : settle_cnt + SW'(1);
      end else begin
         settle_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_cnt     <= '0;
         ones_cnt     <= '0;
         bit_cnt      <= '0;
         resp_data    <= '0;
         unstable_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  eval_cnt     <= '0;
                  ones_cnt     <= '0;
                  bit_cnt      <= '0;
                  resp_data    <= '0;
                  unstable_cnt <= '0;
               end
            end
            SAMPLE: begin
               ones_cnt <= ones_cnt + OW'(sampled);
               if (eval_cnt != EVAL_LAST) eval_cnt <= eval_cnt + EW'(1);
            end
            VOTE: begin
               // First challenge's bit shifts up to the MSB by the end of the run.
               resp_data <= {resp_data[RESP_BITS-2:0], vote_bit};
               if ((ones_cnt != '0) && (ones_cnt != ONES_ALL))
                  unstable_cnt <= unstable_cnt + UW'(1);
               eval_cnt <= '0;
               ones_cnt <= '0;
               if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
